// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Purpose  : First-word-fall-through circular instruction queue between the
//            I-cache and decode. Defining INST_Q_BYPASS_EN adds a
//            zero-latency path that serves an arriving instruction to decode
//            directly while the queue is empty.
// Revision : 1.0  initial release
// ============================================================================
module inst_queue #(
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enq_valid,
   input  logic [ADDR_WIDTH-1:0]    enq_pc,
   input  logic [DATA_WIDTH-1:0]    enq_instr,
   output logic                     full,
   input  logic                     deq_ready,
   output logic                     deq_valid,
   output logic [ADDR_WIDTH-1:0]    deq_pc,
   output logic [DATA_WIDTH-1:0]    deq_instr,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int                 c_PTR_W  = $clog2(DEPTH);
   localparam int                 c_ENT_W  = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [c_PTR_W:0]   c_FULL   = (c_PTR_W + 1)'(DEPTH);

   logic [c_ENT_W-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W:0]     r_count;
   logic                 r_overflow;

   logic                 w_full;
   logic                 w_not_empty;
   logic                 w_bypass;
   logic                 w_push;
   logic                 w_pop;
   logic [c_ENT_W-1:0]   w_head;

   assign w_full      = (r_count == c_FULL);
   assign w_not_empty = (r_count != '0);

`ifdef INST_Q_BYPASS_EN
   assign w_bypass = ~w_not_empty & enq_valid & deq_ready & ~flush;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed instruction is consumed directly and never stored.
   assign w_push = enq_valid & ~w_full & ~flush & ~w_bypass;
   assign w_pop  = w_not_empty & deq_ready & ~flush;

   assign w_head    = r_mem[r_rd_ptr];
   assign deq_valid = w_not_empty | w_bypass;
   assign deq_pc    = w_bypass ? enq_pc    : w_head[c_ENT_W-1:DATA_WIDTH];
   assign deq_instr = w_bypass ? enq_instr : w_head[DATA_WIDTH-1:0];
   assign full      = w_full;
   assign count     = r_count;
   assign overflow  = r_overflow;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {enq_pc, enq_instr};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         // Overflow records any lost fetch, so it ignores flush.
         if (enq_valid & w_full) begin
            r_overflow <= 1'b1;
         end
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue
// Purpose  : Scoreboard bench for inst_queue: directed scenarios followed by
//            randomized traffic against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_queue;

   localparam int DEPTH = 8;
   localparam int AW    = 32;
   localparam int DW    = 32;
`ifdef INST_Q_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     enq_valid;
   logic [AW-1:0]            enq_pc;
   logic [DW-1:0]            enq_instr;
   logic                     full;
   logic                     deq_ready;
   logic                     deq_valid;
   logic [AW-1:0]            deq_pc;
   logic [DW-1:0]            deq_instr;
   logic                     flush;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;

   inst_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .enq_valid (enq_valid),
      .enq_pc    (enq_pc),
      .enq_instr (enq_instr),
      .full      (full),
      .deq_ready (deq_ready),
      .deq_valid (deq_valid),
      .deq_pc    (deq_pc),
      .deq_instr (deq_instr),
      .flush     (flush),
      .count     (count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
   } ent_t;

   ent_t sb[$];
   int   m_count  = 0;
   bit   m_ovf    = 1'b0;
   bit   exp_dv   = 1'b0;
   bit   started  = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: check registered state, apply inputs, then commit the model.
   task automatic step(input bit r, input bit f, input bit ev, input logic [AW-1:0] pc,
                       input logic [DW-1:0] ins, input bit dr);
      bit byp;
      int push;
      int pop;
      @(posedge clk);
      #1;
      chk("count", count, m_count);
      chk("full", full, m_count == DEPTH);
      chk("overflow", overflow, m_ovf);
      rst       = r;
      flush     = f;
      enq_valid = ev;
      enq_pc    = pc;
      enq_instr = ins;
      deq_ready = dr;
      byp    = BYP && (m_count == 0) && ev && dr && !f;
      exp_dv = (m_count != 0) || byp;
      if (byp) sb.push_back({pc, ins});
      @(negedge clk);
      #1;
      if (r) begin
         sb.delete();
         m_count = 0;
         m_ovf   = 1'b0;
      end else begin
         if (ev && m_count == DEPTH) m_ovf = 1'b1;
         if (f) begin
            sb.delete();
            m_count = 0;
         end else begin
            push = (ev && m_count < DEPTH && !byp) ? 1 : 0;
            pop  = (m_count != 0 && dr) ? 1 : 0;
            if (push == 1) sb.push_back({pc, ins});
            m_count = m_count + push - pop;
         end
      end
   endtask

   // Monitor: compares the presented head against the scoreboard and retires it on consumption.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("deq_valid", deq_valid, exp_dv);
            if (deq_valid && exp_dv) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_underflow actual=valid_head required=no_entry at %0t", $time);
               end else begin
                  chk("deq_pc", deq_pc, sb[0].pc);
                  chk("deq_instr", deq_instr, sb[0].instr);
                  if (deq_ready && !flush) void'(sb.pop_front());
               end
            end
         end
      end
   end

   task automatic run(input int n, input bit ev, input bit dr, input logic [AW-1:0] base);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, ev, base + AW'(4 * i), $urandom, dr);
      end
   endtask

   initial begin
      int pe;
      int pd;
      rst       = 1'b1;
      flush     = 1'b0;
      enq_valid = 1'b0;
      enq_pc    = '0;
      enq_instr = '0;
      deq_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      started = 1'b1;

      // Fill to full, then one more fetch to raise overflow.
      run(8, 1'b1, 1'b0, 32'h0);
      run(1, 1'b1, 1'b0, 32'h20);
      run(1, 1'b0, 1'b0, 32'h0);
      // Push and pop while full: push rejected, count drops to 7.
      run(1, 1'b1, 1'b1, 32'h100);
      run(7, 1'b0, 1'b1, 32'h0);
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

      // FIFO order across the pointer wrap.
      run(6, 1'b1, 1'b0, 32'h1000);
      run(6, 1'b0, 1'b1, 32'h0);
      run(6, 1'b1, 1'b0, 32'h2000);
      run(6, 1'b0, 1'b1, 32'h0);

      // Simultaneous push and pop at count 3.
      run(3, 1'b1, 1'b0, 32'h3000);
      run(2, 1'b1, 1'b1, 32'h3100);
      run(3, 1'b0, 1'b1, 32'h0);

      // Flush at count 5 with a fetch arriving.
      run(5, 1'b1, 1'b0, 32'h4000);
      step(1'b0, 1'b1, 1'b1, 32'h4444, $urandom, 1'b0);
      run(1, 1'b0, 1'b0, 32'h0);

      // Reset while count 4 with overflow set.
      run(9, 1'b1, 1'b0, 32'h5000);
      run(4, 1'b0, 1'b1, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h5555, $urandom, 1'b0);
      run(1, 1'b0, 1'b0, 32'h0);

      // Fetch into an empty queue with decode ready.
      step(1'b0, 1'b0, 1'b1, 32'h400, $urandom, 1'b1);
      run(1, 1'b0, 1'b0, 32'h0);
      run(2, 1'b0, 1'b1, 32'h0);

      // Randomized traffic in phases of varying fetch/decode pressure.
      for (int ph = 0; ph < 30; ph++) begin
         pe = int'($urandom_range(10, 90));
         pd = int'($urandom_range(10, 90));
         for (int c = 0; c < 100; c++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                 int'($urandom_range(0, 99)) < pe, $urandom, $urandom,
                 int'($urandom_range(0, 99)) < pd);
         end
      end
      run(1, 1'b0, 1'b0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
